// File: rtl/dbus_xfer_seq.sv
// dbus_xfer_seq: round-robin sequencer for register-to-register moves over the
// shared open-drain data bus. Each transfer precharges the bus, drives the
// source register, clocks the destination once, then holds the source for
// hold time. Every output is a flop, so the write clocks (wra) are glitch-free.
module dbus_xfer_seq #(
    parameter int NREQ    = 2,
    parameter int NREGS   = 4,
    parameter int SELW    = 2,
    parameter int PRE_CYC = 1,
    parameter int SETTLE  = 2
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SELW-1:0] src,
    input  logic [NREQ*SELW-1:0] dst,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic [NREGS-1:0]     rda,
    output logic [NREGS-1:0]     wra,
    output logic                 busy
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DRIVE,
        S_LATCH,
        S_HOLD
    } state_t;

    state_t          state;
    logic [3:0]      tmr;
    logic [PTRW-1:0] ptr;
    logic [SELW-1:0] src_q;
    logic [SELW-1:0] dst_q;
    logic            bad_q;

    logic [PTRW-1:0] win;
    logic [PTRW-1:0] ptr_nxt;
    logic [SELW-1:0] src_w;
    logic [SELW-1:0] dst_w;

    // One-hot decode of a register index; an out-of-range index decodes to zero.
    function automatic logic [NREGS-1:0] reg_dec(input logic [SELW-1:0] s);
        logic [NREGS-1:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (s == SELW'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // True when an index names an existing register.
    function automatic logic in_range(input logic [SELW-1:0] s);
        return (32'(s) < 32'(NREGS));
    endfunction

    // First requester at or after the pointer, wrapping; the lowest offset wins.
    function automatic logic [PTRW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                 input logic [PTRW-1:0] p);
        logic [PTRW-1:0] w;
        int              idx;
        w = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NREQ;
            if (r[idx]) w = PTRW'(idx);
        end
        return w;
    endfunction

    // Arbitration winner, its indices and the pointer value that follows it.
    always_comb begin
        win     = rr_pick(req, ptr);
        ptr_nxt = PTRW'((int'(win) + 1) % NREQ);
        src_w   = src[win*SELW +: SELW];
        dst_w   = dst[win*SELW +: SELW];
    end

    // Transfer sequencer: state, timer, pointer and all registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
            tmr   <= '0;
            ptr   <= '0;
            src_q <= '0;
            dst_q <= '0;
            bad_q <= 1'b0;
            gnt   <= '0;
            done  <= '0;
            err   <= '0;
            rda   <= '0;
            wra   <= '0;
            busy  <= 1'b0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                S_IDLE: begin
                    rda <= '0;
                    wra <= '0;
                    if (|req) begin
                        gnt   <= NREQ'(1) << win;
                        src_q <= src_w;
                        dst_q <= dst_w;
                        // A bad index is reported from PRE so no strobe is ever issued.
                        bad_q <= !(in_range(src_w) && in_range(dst_w));
                        ptr   <= ptr_nxt;
                        tmr   <= 4'(PRE_CYC - 1);
                        busy  <= 1'b1;
                        state <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (bad_q) begin
                        err   <= gnt;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (tmr == 4'd0) begin
                        rda   <= reg_dec(src_q);
                        tmr   <= 4'(SETTLE - 1);
                        state <= S_DRIVE;
                    end else begin
                        tmr <= tmr - 4'd1;
                    end
                end
                S_DRIVE: begin
                    if (tmr == 4'd0) begin
                        wra   <= reg_dec(dst_q);
                        state <= S_LATCH;
                    end else begin
                        tmr <= tmr - 4'd1;
                    end
                end
                S_LATCH: begin
                    // Single-cycle write clock; the source keeps driving for hold time.
                    wra   <= '0;
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    rda   <= '0;
                    done  <= gnt;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    rda   <= '0;
                    wra   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_xfer_seq.sv
// Bench for dbus_xfer_seq: directed transfers with expected responses queued
// by the stimulus and checked by an independent monitor, plus an open-drain
// bus model with four one-bit register slices.
module tb_dbus_xfer_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst;

    // Instance A: default parameters, attached to the bus model
    logic [1:0] req, gnt, done, err;
    logic [3:0] src, dst;
    logic [3:0] rda, wra;
    logic       busy;

    // Instance B: three registers, so index 3 is out of range
    logic [1:0] reqb, gntb, doneb, errb;
    logic [3:0] srcb, dstb;
    logic [2:0] rdab, wrab;
    logic       busyb;

    dbus_xfer_seq #(.NREQ(2), .NREGS(4), .SELW(2), .PRE_CYC(1), .SETTLE(2)) u_a (
        .clk(clk), .nrst(nrst), .req(req), .src(src), .dst(dst),
        .gnt(gnt), .done(done), .err(err), .rda(rda), .wra(wra), .busy(busy)
    );

    dbus_xfer_seq #(.NREQ(2), .NREGS(3), .SELW(2), .PRE_CYC(1), .SETTLE(2)) u_b (
        .clk(clk), .nrst(nrst), .req(reqb), .src(srcb), .dst(dstb),
        .gnt(gntb), .done(doneb), .err(errb), .rda(rdab), .wra(wrab), .busy(busyb)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit is_err;
        int idx;
        int s;
        int d;
        int gap;
    } exp_t;

    exp_t expq[$];
    exp_t me;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Open-drain bus: pulled high, any enabled register holding 0 pulls it low.
    logic [3:0] bregs    = 4'b1101;
    logic [3:0] wra_prev = 4'b0000;
    wire        dbus     = &(~rda | bregs);

    always @(wra) begin
        for (int i = 0; i < 4; i++) begin
            if (wra[i] && !wra_prev[i]) bregs[i] = dbus;
        end
        wra_prev = wra;
    end

    // Monitor for instance A
    logic [1:0] gnt_prev  = 2'b00;
    int         g_cyc     = 0;
    int         g_vec     = 0;
    int         rda_cnt   = 0;
    int         rda_first = 0;
    int         rda_vec   = 0;
    int         wra_cnt   = 0;
    int         wra_first = 0;
    int         wra_vec   = 0;
    int         last_done = -100;

    always @(negedge clk) begin
        if (!nrst) begin
            gnt_prev = 2'b00;
            rda_cnt  = 0;
            wra_cnt  = 0;
        end else begin
            chk("gnt_onehot0", int'($onehot0(gnt)), 1);
            chk("rda_onehot0", int'($onehot0(rda)), 1);
            chk("wra_onehot0", int'($onehot0(wra)), 1);
            if (gnt != 2'b00 && gnt_prev == 2'b00) begin
                g_cyc   = cyc;
                g_vec   = int'(gnt);
                rda_cnt = 0;
                wra_cnt = 0;
            end
            if (rda != 4'b0000) begin
                if (rda_cnt == 0) begin
                    rda_first = cyc - g_cyc;
                    rda_vec   = int'(rda);
                end
                rda_cnt++;
            end
            if (wra != 4'b0000) begin
                if (wra_cnt == 0) begin
                    wra_first = cyc - g_cyc;
                    wra_vec   = int'(wra);
                end
                wra_cnt++;
            end
            if ((done | err) != 2'b00) begin
                if (expq.size() == 0) begin
                    chk("unexpected_completion", int'({err, done}), 0);
                end else begin
                    me = expq.pop_front();
                    chk("kind_is_err", int'(err != 2'b00), me.is_err ? 1 : 0);
                    chk("done_vec", int'(done), 1 << me.idx);
                    chk("grant_vec", g_vec, 1 << me.idx);
                    chk("grant_to_done", cyc - g_cyc, 5);
                    chk("rda_first_cycle", rda_first, 1);
                    chk("rda_cycles", rda_cnt, 4);
                    chk("rda_src", rda_vec, 1 << me.s);
                    chk("wra_first_cycle", wra_first, 3);
                    chk("wra_cycles", wra_cnt, 1);
                    chk("wra_dst", wra_vec, 1 << me.d);
                    chk("gnt_low_in_done", int'(gnt), 0);
                    chk("busy_low_in_done", int'(busy), 0);
                    if (me.gap != 0) chk("idle_gap", g_cyc - last_done, me.gap);
                end
                last_done = cyc;
            end
            gnt_prev = gnt;
        end
    end

    task automatic wait_done_a(input int i);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done[i] && t < 30);
        if (!done[i]) chk("done_timeout", 0, 1);
    endtask

    task automatic do_xfer(input int i, input int s, input int d);
        src[i*2 +: 2] = 2'(s);
        dst[i*2 +: 2] = 2'(d);
        expq.push_back('{1'b0, i, s, d, 0});
        req[i] = 1'b1;
        wait_done_a(i);
        req[i] = 1'b0;
    endtask

    task automatic err_case(input string nm);
        int err_k, err_v, nerr, act, ndone, g1;
        err_k = -1; err_v = 0; nerr = 0; act = 0; ndone = 0; g1 = 0;
        reqb[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) g1 = int'(gntb);
            if (errb != 2'b00) begin
                nerr++;
                if (err_k < 0) begin
                    err_k = k;
                    err_v = int'(errb);
                end
                reqb[0] = 1'b0;
            end
            if (rdab != 3'b000 || wrab != 3'b000) act++;
            if (doneb != 2'b00) ndone++;
        end
        reqb[0] = 1'b0;
        chk({nm, "_grant"}, g1, 1);
        chk({nm, "_err_cycle"}, err_k, 2);
        chk({nm, "_err_vec"}, err_v, 1);
        chk({nm, "_err_pulses"}, nerr, 1);
        chk({nm, "_strobes"}, act, 0);
        chk({nm, "_done_pulses"}, ndone, 0);
    endtask

    initial begin
        int n, t;
        nrst = 1'b0;
        req  = 2'b00; src  = 4'h0; dst  = 4'h0;
        reqb = 2'b00; srcb = 4'h0; dstb = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_rda", int'(rda), 0);
        chk("rst_wra", int'(wra), 0);
        chk("rst_busy", int'(busy), 0);
        nrst = 1'b1;
        @(negedge clk);

        // Bus transfers 1->0 then 0->2 from preload 1,0,1,1
        do_xfer(0, 1, 0);
        do_xfer(0, 0, 2);
        chk("bus_regs", int'(bregs), 8);

        // Reset while driving: a 0->3 move would clear reg3 if it completed
        src[1:0] = 2'd0;
        dst[1:0] = 2'd3;
        req      = 2'b01;
        repeat (2) @(negedge clk);
        chk("drive_rda_before_reset", int'(rda), 1);
        nrst = 1'b0;
        #1;
        chk("async_rst_rda", int'(rda), 0);
        chk("async_rst_wra", int'(wra), 0);
        chk("async_rst_gnt", int'(gnt), 0);
        chk("async_rst_busy", int'(busy), 0);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        chk("abandoned_regs", int'(bregs), 8);

        // Round-robin with both held; pointer must restart at 0
        src = {2'd2, 2'd1};
        dst = {2'd0, 2'd3};
        expq.push_back('{1'b0, 0, 1, 3, 0});
        expq.push_back('{1'b0, 1, 2, 0, 1});
        expq.push_back('{1'b0, 0, 1, 3, 1});
        expq.push_back('{1'b0, 1, 2, 0, 1});
        req = 2'b11;
        n = 0;
        for (t = 0; t < 200 && n < 4; t++) begin
            @(negedge clk);
            if (done != 2'b00) n++;
        end
        req = 2'b00;
        chk("rr_completions", n, 4);
        repeat (2) @(negedge clk);

        // Reference single transfer 1->3
        do_xfer(0, 1, 3);
        repeat (2) @(negedge clk);

        // Request withdrawn in PRE, indices changed after grant
        src[1:0] = 2'd2;
        dst[1:0] = 2'd1;
        expq.push_back('{1'b0, 0, 2, 1, 0});
        req[0] = 1'b1;
        @(negedge clk);
        chk("pre_busy", int'(busy), 1);
        req[0]   = 1'b0;
        src[1:0] = 2'd3;
        dst[1:0] = 2'd3;
        wait_done_a(0);
        repeat (2) @(negedge clk);

        // Source equals destination
        do_xfer(1, 2, 2);
        repeat (2) @(negedge clk);

        // Out-of-range source, then destination, on instance B
        srcb[1:0] = 2'd3;
        dstb[1:0] = 2'd0;
        err_case("oor_src");
        srcb[1:0] = 2'd0;
        dstb[1:0] = 2'd3;
        err_case("oor_dst");

        // Pointer advanced past requester 0 despite the errors
        srcb = {2'd1, 2'd0};
        dstb = {2'd2, 2'd1};
        reqb = 2'b11;
        @(negedge clk);
        chk("ptr_after_err", int'(gntb), 2);
        reqb = 2'b10;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (doneb == 2'b00 && t < 30);
        chk("ptr_after_err_done", int'(doneb), 2);
        reqb = 2'b00;

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
